// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed 7-segment bus: waits for each digit to settle,
// decodes it to a nibble and publishes complete frames as hex digits plus a binary value.
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  seg_comm,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic        valid,
  output logic        bcd_err,
  output logic        frame_err,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t      state, state_n;
  logic [7:0]  seg_p0, seg_p1;
  logic [3:0]  comm_p0, comm_p1;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]  mask, mask_n;
  logic [3:0]  nib [4];
  logic [15:0] frame;
  logic        changed, sample, onehot, blank, accept, bad, timeout_hit, publish;
  logic [1:0]  pos;
  logic [4:0]  dec;

  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h40: decode_seg = {1'b1, 4'h0};
      7'h79: decode_seg = {1'b1, 4'h1};
      7'h24: decode_seg = {1'b1, 4'h2};
      7'h30: decode_seg = {1'b1, 4'h3};
      7'h19: decode_seg = {1'b1, 4'h4};
      7'h12: decode_seg = {1'b1, 4'h5};
      7'h02: decode_seg = {1'b1, 4'h6};
      7'h78: decode_seg = {1'b1, 4'h7};
      7'h00: decode_seg = {1'b1, 4'h8};
      7'h10: decode_seg = {1'b1, 4'h9};
      7'h08: decode_seg = {1'b1, 4'hA};
      7'h03: decode_seg = {1'b1, 4'hB};
      7'h46: decode_seg = {1'b1, 4'hC};
      7'h21: decode_seg = {1'b1, 4'hD};
      7'h06: decode_seg = {1'b1, 4'hE};
      7'h0E: decode_seg = {1'b1, 4'hF};
      default: decode_seg = 5'b0;
    endcase
  endfunction

  function automatic logic any_non_bcd(input logic [15:0] d);
    any_non_bcd = (d[15:12] > 4'd9) || (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
  endfunction

  function automatic logic [13:0] to_binary(input logic [15:0] d);
    to_binary = {10'b0, d[15:12]} * 14'd1000 + {10'b0, d[11:8]} * 14'd100
              + {10'b0, d[7:4]} * 14'd10 + {10'b0, d[3:0]};
  endfunction

  // Stage p0: input capture; p1: previous capture used for the stability check
  always_ff @(posedge clk) begin
    seg_p0  <= seg;
    comm_p0 <= seg_comm;
    seg_p1  <= seg_p0;
    comm_p1 <= comm_p0;
  end

  assign changed = (seg_p0 != seg_p1) || (comm_p0 != comm_p1);
  assign sample  = !changed && (settle_cnt == SW'(SETTLE_CYCLES - 1));

  // Counter runs one past the sample point so each dwell yields exactly one sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) settle_cnt <= '0;
    else if (changed) settle_cnt <= '0;
    else if (settle_cnt != SW'(SETTLE_CYCLES)) settle_cnt <= settle_cnt + 1'b1;
  end

  always_comb begin
    onehot = 1'b1;
    blank  = 1'b0;
    pos    = 2'd0;
    case (comm_p0)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      4'b1111: begin onehot = 1'b0; blank = 1'b1; end
      default: onehot = 1'b0;
    endcase
  end

  assign dec         = decode_seg(seg_p0[6:0]);
  assign accept      = sample && onehot && dec[4];
  assign bad         = sample && !blank && !(onehot && dec[4]);
  assign timeout_hit = !accept && (to_cnt == TW'(TIMEOUT - 1));
  assign publish     = (state == PUBLISH);
  assign frame       = {nib[3], nib[2], nib[1], nib[0]};

  always_ff @(posedge clk) begin
    if (accept) nib[pos] <= dec[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt <= '0;
    else if (accept) to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
      mask  <= 4'b0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
    end
  end

  // A repeated position means the previous partial frame is stale: restart from that digit
  always_comb begin
    state_n = state;
    mask_n  = mask;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (mask[pos]) mask_n = 4'b1 << pos;
          else           mask_n = mask | (4'b1 << pos);
          if (mask_n == 4'hF) state_n = PUBLISH;
        end else if (timeout_hit) begin
          mask_n = 4'b0;
        end
      end
      PUBLISH: begin
        state_n = COLLECT;
        mask_n  = accept ? (4'b1 << pos) : 4'b0;
      end
      default: begin
        state_n = COLLECT;
        mask_n  = 4'b0;
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits    <= '0;
      value     <= '0;
      valid     <= 1'b0;
      bcd_err   <= 1'b0;
      frame_err <= 1'b0;
      stale     <= 1'b0;
    end else begin
      valid     <= publish;
      frame_err <= bad && !publish;
      if (publish) begin
        digits  <= frame;
        bcd_err <= any_non_bcd(frame);
        if (!any_non_bcd(frame)) value <= to_binary(frame);
        stale   <= 1'b0;
      end else if (timeout_hit) begin
        stale   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: drives scanned 7-segment digits and checks decoded frames.
module tb_fnd_scan_decoder;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg;
  logic [3:0]  seg_comm;
  logic [15:0] digits;
  logic [13:0] value;
  logic        valid, bcd_err, frame_err, stale;

  int total = 0;
  int passes = 0;
  int vcnt = 0;
  int fcnt = 0;
  int both = 0;
  int v0, f0;

  fnd_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .seg(seg), .seg_comm(seg_comm),
    .digits(digits), .value(value), .valid(valid), .bcd_err(bcd_err),
    .frame_err(frame_err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vcnt++;
    if (frame_err) fcnt++;
    if (valid && frame_err) both++;
  end

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'h40; 4'h1: pat = 7'h79; 4'h2: pat = 7'h24; 4'h3: pat = 7'h30;
      4'h4: pat = 7'h19; 4'h5: pat = 7'h12; 4'h6: pat = 7'h02; 4'h7: pat = 7'h78;
      4'h8: pat = 7'h00; 4'h9: pat = 7'h10; 4'hA: pat = 7'h08; 4'hB: pat = 7'h03;
      4'hC: pat = 7'h46; 4'hD: pat = 7'h21; 4'hE: pat = 7'h06; default: pat = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic show(input int pos, input logic [3:0] n, input int dwell);
    @(negedge clk);
    seg      = {1'b1, pat(n)};
    seg_comm = ~(4'b0001 << pos);
    repeat (dwell - 1) @(negedge clk);
  endtask

  task automatic blank(input int n);
    @(negedge clk);
    seg      = 8'hFF;
    seg_comm = 4'b1111;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; seg = 8'hFF; seg_comm = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits, 16'h0);
    chk("rst_value", value, 14'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_bcd_err", bcd_err, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_stale", stale, 1'b0);
    @(negedge clk); reset = 1'b0;

    // 1: plain scan of 1234
    v0 = vcnt;
    show(0, 4'h4, 10); show(1, 4'h3, 10); show(2, 4'h2, 10); show(3, 4'h1, 10);
    chk("t1_valid_pulses", vcnt - v0, 1);
    chk("t1_digits", digits, 16'h1234);
    chk("t1_value", value, 14'd1234);
    chk("t1_bcd_err", bcd_err, 1'b0);
    chk("t1_stale", stale, 1'b0);

    // 2: short glitch on digit 2 is not sampled
    v0 = vcnt;
    show(0, 4'h4, 10); show(1, 4'h3, 10); show(2, 4'h9, 2); show(2, 4'h2, 10); show(3, 4'h1, 10);
    chk("t2_valid_pulses", vcnt - v0, 1);
    chk("t2_digits", digits, 16'h1234);

    // 3: unknown pattern on digit 2, blanks cause no error
    v0 = vcnt; f0 = fcnt;
    blank(10);
    chk("t3_blank_no_err", fcnt - f0, 0);
    show(0, 4'h4, 10); show(1, 4'h3, 10);
    @(negedge clk); seg = 8'hFF; seg_comm = 4'b1011;
    repeat (9) @(negedge clk);
    show(3, 4'h1, 10);
    chk("t3_frame_err_cycles", fcnt - f0, 1);
    chk("t3_no_valid_yet", vcnt - v0, 0);
    @(negedge clk); seg = 8'h24; seg_comm = 4'b1011;  // dp lit, must be ignored
    repeat (9) @(negedge clk);
    chk("t3_valid_after_resend", vcnt - v0, 1);
    chk("t3_digits", digits, 16'h1234);

    // 4: non-BCD digit flags bcd_err and holds value
    v0 = vcnt;
    show(0, 4'h7, 10); show(1, 4'h0, 10); show(2, 4'h0, 10); show(3, 4'hA, 10);
    chk("t4_valid_pulses", vcnt - v0, 1);
    chk("t4_digits", digits, 16'hA007);
    chk("t4_bcd_err", bcd_err, 1'b1);
    chk("t4_value_held", value, 14'd1234);

    // 5: partial frame then timeout; stale rises and partial is dropped
    v0 = vcnt;
    show(3, 4'h9, 10); show(2, 4'h9, 10);
    blank(TO + 10);
    chk("t5_stale_high", stale, 1'b1);
    show(0, 4'h2, 10); show(1, 4'h4, 10);
    chk("t5_no_early_frame", vcnt - v0, 0);
    show(2, 4'h0, 10); show(3, 4'h0, 10);
    chk("t5_valid_pulses", vcnt - v0, 1);
    chk("t5_value", value, 14'd42);
    chk("t5_digits", digits, 16'h0042);
    chk("t5_stale_low", stale, 1'b0);
    chk("t5_bcd_err", bcd_err, 1'b0);

    // 6: reset mid-frame discards collected digits
    show(0, 4'h8, 10); show(1, 4'h7, 10);
    @(negedge clk);
    reset = 1'b1; seg = 8'hFF; seg_comm = 4'b1111;
    #1;
    chk("t6_rst_digits", digits, 16'h0);
    chk("t6_rst_value", value, 14'd0);
    chk("t6_rst_stale", stale, 1'b0);
    chk("t6_rst_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = vcnt;
    show(2, 4'h6, 10); show(3, 4'h5, 10);
    chk("t6_no_frame_after_reset", vcnt - v0, 0);
    show(1, 4'h7, 10); show(0, 4'h8, 10);
    chk("t6_valid_pulses", vcnt - v0, 1);
    chk("t6_value", value, 14'd5678);
    chk("t6_digits", digits, 16'h5678);

    chk("never_valid_and_frame_err", both, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
